alu_issue_unit: RTL
===================

# alu_issue_unit

- Decodes a MIPS opcode/funct request into the 3-bit ALU select and prepares the operands (register or extended immediate).
- Drives the 32-bit combinational ALU from registered outputs, captures its result, and returns it with zero/error (optionally overflow) flags.
- Sits between instruction decode and the `_32bit_alu` instance: it is the hardware initiator of the ALU select/operand interface.

## Interface
- `DATA_W`, 32, operand/result width (fixed by ALU; only 32 supported)
- `clk` in 1: single clock, rising edge
- `rst_n` in 1: synchronous, active-low reset
- `req_valid` in 1: request present
- `req_ready` out 1: unit can accept; high only in IDLE
- `req_op` in 6: MIPS opcode
- `req_funct` in 6: MIPS funct (used when `req_op`=0)
- `req_rs`, `req_rt` in 32: register operands
- `req_imm` in 16: immediate
- `alu_a`, `alu_b` out 32: registered ALU operands
- `alu_sel` out 3: registered ALU select
- `alu_out` in 32: ALU result (combinational from `alu_a`/`alu_b`/`alu_sel`)
- `rsp_valid` out 1, `rsp_ready` in 1: response handshake
- `rsp_data` out 32: result; `rsp_zero` out 1: `rsp_data`==0
- `rsp_err` out 1: unsupported op; `rsp_ovf` out 1: signed overflow (macro only, else tied 0)

## Operation
- ALU select encoding: add 000, xor 001, sub 010, slt 100, nor 101, and 110, or 111; 011 never issued.
- R-type (op 0x00), B=`req_rt`: funct 0x20/0x21 add, 0x22/0x23 sub, 0x24 and, 0x25 or, 0x26 xor, 0x27 nor, 0x2A slt.
- I-type, B=immediate: 0x08/0x09 addi/addiu add; 0x0A slti slt; 0x23 lw and 0x2B sw add; sign-extended.
- I-type, zero-extended immediate: 0x0C andi, 0x0D ori, 0x0E xori.
- beq 0x04 / bne 0x05: sub with B=`req_rt`.
- A is always `req_rs`.
- Any other op/funct: error path, ALU outputs unchanged.
- FSM states: IDLE, EXEC, RESP.
- IDLE: `req_ready`=1; on `req_valid`, register decode -> EXEC (legal) or RESP with `rsp_err`=1, `rsp_data`=0 (illegal).
- EXEC: one cycle for ALU settling; capture `alu_out` into `rsp_data`, compute flags -> RESP.
- RESP: `rsp_valid`=1; `rsp_data`/flags stable; on `rsp_ready` -> IDLE, `rsp_valid` drops next cycle.
- No overlap: at most one request in flight.

## Timing
- Reset: state IDLE; `alu_a`, `alu_b`, `rsp_data` = 0; `alu_sel`=000; `rsp_valid`, `rsp_zero`, `rsp_err`, `rsp_ovf` = 0; `req_ready`=0 while `rst_n` low.
- Legal request accepted at edge N: `alu_*` valid after N; `rsp_valid` high after N+1 (latency 2).
- Error request: `rsp_valid` after N (latency 1).
- Best throughput: one request per 3 cycles (accept, EXEC, RESP with `rsp_ready`=1).
- Back-pressure: RESP held indefinitely; `req_ready`=0 throughout.
- `rsp_ready` asserted before `rsp_valid`: no effect.
- Reset low in any state: IDLE on that edge, in-flight op discarded, no response.

## Configuration
- `ALU_ISSUE_OVF_EN` defined: `rsp_ovf` captured in EXEC for add/addi only: (a31==b31)&&(r31!=a31); sub only: (a31!=b31)&&(r31!=a31).
- Unsigned, branch, lw/sw, logic and slt ops never set `rsp_ovf`.
- Without the macro: `rsp_ovf` constant 0; no overflow logic synthesized.

## Test plan
- R add, rs=5, rt=7, `rsp_ready`=1: `alu_sel`=000; `rsp_data`=12, `rsp_zero`=0 two cycles after accept; `req_ready` back next cycle.
- beq, rs=rt=0x3: sel 010; `rsp_data`=0, `rsp_zero`=1.
- andi, rs=0xFFFFFFFF, imm=0x8001: B=0x00008001, `rsp_data`=0x00008001. slti, rs=0, imm=0xFFFF: B=0xFFFFFFFF, `rsp_data`=0.
- add 0x7FFFFFFF+0x1: `rsp_data`=0x80000000, `rsp_ovf`=1 with macro, 0 without. addu same operands: `rsp_ovf`=0.
- op 0, funct 0x18: `rsp_err`=1, `rsp_data`=0, latency 1. Hold `rsp_ready`=0 for 5 cycles: response stable, `req_ready`=0.
- Reset pulsed in EXEC: next cycle all outputs at reset values, no `rsp_valid`; next request completes normally.

Source files
------------

// File: rtl/alu_issue_unit_if.sv
// ALU issue bus: request, ALU select/operand and response signal bundle.
// Latency: none (wiring only).
// Backpressure: req_valid/req_ready on the request side, rsp_valid/rsp_ready on the response side.
//
// Modports:
//   master - the issue unit: consumes requests, drives alu_a/alu_b/alu_sel,
//            reads alu_out, produces responses.
//   slave  - the surroundings: decode stage, the 32-bit ALU and the result sink.
interface alu_issue_unit_if #(
    parameter int DATA_W = 32
);
    // request from instruction decode
    logic              req_valid;
    logic              req_ready;
    logic [5:0]        req_op;
    logic [5:0]        req_funct;
    logic [DATA_W-1:0] req_rs;
    logic [DATA_W-1:0] req_rt;
    logic [15:0]       req_imm;

    // ALU select/operand bus (alu_out is combinational from the other three)
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [2:0]        alu_sel;
    logic [DATA_W-1:0] alu_out;

    // response
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_zero;
    logic              rsp_err;
    logic              rsp_ovf;

    modport master (
        input  req_valid, req_op, req_funct, req_rs, req_rt, req_imm,
        output req_ready,
        output alu_a, alu_b, alu_sel,
        input  alu_out,
        output rsp_valid, rsp_data, rsp_zero, rsp_err, rsp_ovf,
        input  rsp_ready
    );

    modport slave (
        output req_valid, req_op, req_funct, req_rs, req_rt, req_imm,
        input  req_ready,
        input  alu_a, alu_b, alu_sel,
        output alu_out,
        input  rsp_valid, rsp_data, rsp_zero, rsp_err, rsp_ovf,
        output rsp_ready
    );
endinterface

// File: rtl/alu_issue_unit.sv
// ALU issue unit: decodes MIPS opcode/funct into an ALU select, registers operands, returns the ALU result with flags.
// Latency: legal request 2 cycles accept-to-rsp_valid, illegal request 1 cycle; one request in flight (3-cycle best throughput).
// Backpressure: response held in RESP until rsp_ready; req_ready is low everywhere except IDLE.
//
// Ports:
//   clk    - rising-edge clock
//   rst_n  - synchronous active-low reset (req_ready forced low while asserted)
//   bus    - alu_issue_unit_if.master: req_* in, alu_a/alu_b/alu_sel out, alu_out in,
//            rsp_valid/rsp_data/rsp_zero/rsp_err/rsp_ovf out, rsp_ready in
//
// Optional feature: define ALU_ISSUE_OVF_EN to capture signed overflow of add/addi/sub
// into rsp_ovf. Without it rsp_ovf is constant 0 and no overflow logic exists.
module alu_issue_unit #(
    parameter int DATA_W = 32   // operand/result width; the attached ALU only supports 32
) (
    input  logic             clk,
    input  logic             rst_n,
    alu_issue_unit_if.master bus
);

    // ALU select encoding (3'b011 is never issued)
    localparam logic [2:0] SEL_ADD = 3'b000;
    localparam logic [2:0] SEL_XOR = 3'b001;
    localparam logic [2:0] SEL_SUB = 3'b010;
    localparam logic [2:0] SEL_SLT = 3'b100;
    localparam logic [2:0] SEL_NOR = 3'b101;
    localparam logic [2:0] SEL_AND = 3'b110;
    localparam logic [2:0] SEL_OR  = 3'b111;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [1:0]        state;
    logic [DATA_W-1:0] alu_a_q;
    logic [DATA_W-1:0] alu_b_q;
    logic [2:0]        alu_sel_q;
    logic [DATA_W-1:0] rsp_data_q;
    logic              rsp_zero_q;
    logic              rsp_err_q;

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    logic              dec_legal;
    logic [2:0]        dec_sel;
    logic [DATA_W-1:0] dec_b;
    logic [DATA_W-1:0] imm_sext;
    logic [DATA_W-1:0] imm_zext;
`ifdef ALU_ISSUE_OVF_EN
    logic              dec_ovf_add;   // signed add: add, addi
    logic              dec_ovf_sub;   // signed sub: sub only (not subu, not branches)
`endif

    assign imm_sext = {{(DATA_W-16){bus.req_imm[15]}}, bus.req_imm};
    assign imm_zext = {{(DATA_W-16){1'b0}}, bus.req_imm};

    always_comb begin
        dec_legal = 1'b1;
        dec_sel   = SEL_ADD;
        dec_b     = bus.req_rt;
`ifdef ALU_ISSUE_OVF_EN
        dec_ovf_add = 1'b0;
        dec_ovf_sub = 1'b0;
`endif
        case (bus.req_op)
            6'h00: begin
                case (bus.req_funct)
                    6'h20: begin
                        dec_sel = SEL_ADD;
`ifdef ALU_ISSUE_OVF_EN
                        dec_ovf_add = 1'b1;
`endif
                    end
                    6'h21: dec_sel = SEL_ADD;
                    6'h22: begin
                        dec_sel = SEL_SUB;
`ifdef ALU_ISSUE_OVF_EN
                        dec_ovf_sub = 1'b1;
`endif
                    end
                    6'h23: dec_sel = SEL_SUB;
                    6'h24: dec_sel = SEL_AND;
                    6'h25: dec_sel = SEL_OR;
                    6'h26: dec_sel = SEL_XOR;
                    6'h27: dec_sel = SEL_NOR;
                    6'h2A: dec_sel = SEL_SLT;
                    default: dec_legal = 1'b0;
                endcase
            end
            6'h08: begin
                dec_sel = SEL_ADD;
                dec_b   = imm_sext;
`ifdef ALU_ISSUE_OVF_EN
                dec_ovf_add = 1'b1;
`endif
            end
            6'h09, 6'h23, 6'h2B: begin   // addiu, lw, sw: address/unsigned add
                dec_sel = SEL_ADD;
                dec_b   = imm_sext;
            end
            6'h0A: begin
                dec_sel = SEL_SLT;
                dec_b   = imm_sext;
            end
            6'h0C: begin
                dec_sel = SEL_AND;
                dec_b   = imm_zext;
            end
            6'h0D: begin
                dec_sel = SEL_OR;
                dec_b   = imm_zext;
            end
            6'h0E: begin
                dec_sel = SEL_XOR;
                dec_b   = imm_zext;
            end
            6'h04, 6'h05: dec_sel = SEL_SUB;   // beq/bne compare via subtract, B = rt
            default: dec_legal = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // Control and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_sel_q  <= SEL_ADD;
            rsp_data_q <= '0;
            rsp_zero_q <= 1'b0;
            rsp_err_q  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        if (dec_legal) begin
                            alu_a_q   <= bus.req_rs;
                            alu_b_q   <= dec_b;
                            alu_sel_q <= dec_sel;
                            state     <= ST_EXEC;
                        end else begin
                            // ALU operands left untouched; answer straight away
                            rsp_data_q <= '0;
                            rsp_zero_q <= 1'b1;
                            rsp_err_q  <= 1'b1;
                            state      <= ST_RESP;
                        end
                    end
                end
                ST_EXEC: begin
                    // ALU has had a full cycle to settle on the registered operands
                    rsp_data_q <= bus.alu_out;
                    rsp_zero_q <= (bus.alu_out == '0);
                    rsp_err_q  <= 1'b0;
                    state      <= ST_RESP;
                end
                ST_RESP: begin
                    if (bus.rsp_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef ALU_ISSUE_OVF_EN
    logic ovf_add_q;
    logic ovf_sub_q;
    logic rsp_ovf_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf_add_q <= 1'b0;
            ovf_sub_q <= 1'b0;
            rsp_ovf_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        ovf_add_q <= dec_legal & dec_ovf_add;
                        ovf_sub_q <= dec_legal & dec_ovf_sub;
                        if (!dec_legal) begin
                            rsp_ovf_q <= 1'b0;
                        end
                    end
                end
                ST_EXEC: begin
                    // add: operands agree in sign, result does not
                    // sub: operands differ in sign, result differs from A
                    rsp_ovf_q <= (ovf_add_q && (alu_a_q[DATA_W-1] == alu_b_q[DATA_W-1])
                                            && (bus.alu_out[DATA_W-1] != alu_a_q[DATA_W-1]))
                              || (ovf_sub_q && (alu_a_q[DATA_W-1] != alu_b_q[DATA_W-1])
                                            && (bus.alu_out[DATA_W-1] != alu_a_q[DATA_W-1]));
                end
                default: ;
            endcase
        end
    end

    assign bus.rsp_ovf = rsp_ovf_q;
`else
    assign bus.rsp_ovf = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.req_ready = rst_n && (state == ST_IDLE);
    assign bus.rsp_valid = (state == ST_RESP);
    assign bus.alu_a     = alu_a_q;
    assign bus.alu_b     = alu_b_q;
    assign bus.alu_sel   = alu_sel_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_zero  = rsp_zero_q;
    assign bus.rsp_err   = rsp_err_q;

endmodule
